// File: rtl/md_sched_pkg.sv
// Shared opcodes, state encoding and result payload for the E-stage multiply/divide unit.
package md_defs;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } md_result_t;

    // True for the opcodes that occupy the unit for a multi-cycle latency.
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// E-stage issue / D-stage hazard / HI-LO bundle between the datapath and the MD controller.
interface md_if;
    import md_defs::*;

    logic            e_start;
    logic [OP_W-1:0] e_op;
    logic [XLEN-1:0] e_rs;
    logic [XLEN-1:0] e_rt;
    logic            d_is_md;
    logic            busy;
    logic            stall_md;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output e_start, e_op, e_rs, e_rt, d_is_md,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  e_start, e_op, e_rs, e_rt, d_is_md,
        output busy, stall_md, hi, lo
    );

endinterface

// File: rtl/md_sched_arith.sv
// Combinational multiply/divide datapath; produces the {hi,lo} pair for the issued opcode.
module md_arith
    import md_defs::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    output md_result_t      res_o
);

    logic [2*XLEN-1:0]      prod_s;
    logic [2*XLEN-1:0]      prod_u;
    logic [XLEN-1:0]        divisor;
    logic signed [XLEN-1:0] quot_s;
    logic signed [XLEN-1:0] rem_s;
    logic [XLEN-1:0]        quot_u;
    logic [XLEN-1:0]        rem_u;

    // A zero divisor is replaced so the divider never sees x/0; that result is discarded at commit.
    assign divisor = (rt_i == '0) ? XLEN'(1) : rt_i;

    assign prod_s = {{XLEN{rs_i[XLEN-1]}}, rs_i} * {{XLEN{rt_i[XLEN-1]}}, rt_i};
    assign prod_u = {{XLEN{1'b0}}, rs_i} * {{XLEN{1'b0}}, rt_i};
    assign quot_s = signed'(rs_i) / signed'(divisor);
    assign rem_s  = signed'(rs_i) % signed'(divisor);
    assign quot_u = rs_i / divisor;
    assign rem_u  = rs_i % divisor;

    always_comb begin
        res_o = '0;
        case (op_i)
            MD_MULT:  res_o = prod_s;
            MD_MULTU: res_o = prod_u;
            MD_DIV: begin
                res_o.hi = rem_s;
                res_o.lo = quot_s;
            end
            MD_DIVU: begin
                res_o.hi = rem_u;
                res_o.lo = quot_u;
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: latches the result at issue, holds it for a fixed latency,
// then commits HI/LO and releases the D-stage stall.
module md_sched
    import md_defs::*;
#(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  md
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_result_t       pend_q, pend_d;
    md_result_t       arith_res;
    logic             dz_q, dz_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic             busy_q, busy_d;

    md_arith u_arith (
        .op_i  (md.e_op),
        .rs_i  (md.e_rs),
        .rt_i  (md.e_rt),
        .res_o (arith_res)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    // Issue is only honoured in IDLE; starts arriving while occupied are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (md.e_start) begin
                    case (md.e_op)
                        MD_MULT, MD_MULTU: begin
                            state_d = ST_MUL;
                            cnt_d   = CNT_W'(MUL_LAT);
                            pend_d  = arith_res;
                            dz_d    = 1'b0;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d = ST_DIV;
                            cnt_d   = CNT_W'(DIV_LAT);
                            pend_d  = arith_res;
                            dz_d    = (md.e_rt == '0);
                        end
                        MD_MTHI: hi_d = md.e_rs;
                        MD_MTLO: lo_d = md.e_rs;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (!dz_q) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign md.busy     = busy_q;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.stall_md = md.d_is_md & (busy_q | (md.e_start & is_muldiv(md.e_op)));

endmodule
